slot_game_ctrl: RTL
===================

SLOT_GAME_CTRL -- requirements
Module: slot_game_ctrl

Interface
REQ-001 Parameter SPIN_DIV, default 4: number of frame_tick pulses between reel steps while spinning.
REQ-002 Parameter AUTO_STOP, default 120: number of frame_tick pulses without a stop before the block forces a stop.
REQ-003 Parameter CREDIT_INIT, default 100: credit value loaded at reset.
REQ-004 Parameter CREDIT_MAX, default 999: credit saturation ceiling.
REQ-005 clk  in  1  single system clock (pixel clock domain); all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 btn_spin  in  1  one-cycle pulse, already debounced; requests a spin.
REQ-009 btn_bet  in  1  one-cycle pulse; cycles the bet value.
REQ-010 btn_stop  in  1  one-cycle pulse; stops the next spinning reel.
REQ-011 reel0, reel1, reel2  out  2 each  center-row symbol index per reel; drives the renderer rotation state.
REQ-012 credit  out  10  current balance, unsigned.
REQ-013 bet  out  2  current bet, range 1..3.
REQ-014 spinning  out  1  high while any reel is spinning.
REQ-015 win  out  1  high from EVAL until the next accepted spin when the last payout was greater than 0.
REQ-016 win_amount  out  10  last payout; 0 when no win.

Function
REQ-017 All outputs SHALL be registered, and all state machine states SHALL be IDLE, SPIN3, SPIN2, SPIN1 and EVAL.
REQ-018 IDLE SHALL behave as follows: btn_bet steps bet 1->2->3->1 on the next edge; btn_spin with credit>=bet subtracts bet from credit, clears win and win_amount, clears the divider and auto-stop counters, and enters SPIN3, all on the same edge.
REQ-019 In IDLE, btn_spin with credit<bet SHALL be ignored, with no change to any output.
REQ-020 If btn_spin and btn_bet are asserted in the same IDLE cycle, the spin SHALL be taken using the old bet, and bet SHALL NOT change.
REQ-021 btn_spin and btn_bet SHALL be ignored outside IDLE, and btn_stop SHALL be ignored in IDLE and EVAL.
REQ-022 The divider SHALL count frame_tick pulses; on the tick reaching SPIN_DIV it resets to 0, and each spinning reel increments mod 4 (3 wraps to 0).
REQ-023 Reels SHALL spin by state as follows: SPIN3, all three reels; SPIN2, reel1 and reel2; SPIN1, reel2 only.
REQ-024 Stop transitions SHALL be SPIN3->SPIN2 (reel0 freezes), SPIN2->SPIN1 (reel1 freezes), SPIN1->EVAL (reel2 freezes), each taken on btn_stop or on an auto-stop.
REQ-025 The auto-stop counter SHALL count frame_tick pulses in the SPIN states and clear on every stop; reaching AUTO_STOP SHALL act exactly as a btn_stop.
REQ-026 If a stop and a reel step coincide in one cycle, the stopping reel SHALL NOT step, while the remaining spinning reels SHALL step.
REQ-027 btn_stop and an auto-stop in the same cycle SHALL count as one stop.
REQ-028 EVAL SHALL last exactly one cycle and then return to IDLE, with payout, credit, win and win_amount updated on the EVAL->IDLE edge.
REQ-029 Payout SHALL be computed as follows: if reel0==reel1==reel2, payout = bet*M, where M = 2, 4, 8, 16 for symbols 0, 1, 2, 3; else if reel0==reel1 or reel1==reel2, payout = bet; else payout = 0.
REQ-030 Credit SHALL be updated as credit = min(credit+payout, CREDIT_MAX), and credit SHALL never underflow.
REQ-031 spinning SHALL equal 1 in SPIN3, SPIN2 and SPIN1, and 0 otherwise.

Reset
REQ-032 While rst is high, the block SHALL hold state=IDLE, reel0/1/2=0, credit=CREDIT_INIT, bet=1, win=0, win_amount=0, spinning=0, with both counters at 0.
REQ-033 Asserting rst mid-spin SHALL abort the spin with no refund, and the first edge after rst deasserts SHALL evaluate inputs from IDLE.

Verification
REQ-034 Reset then btn_bet x2, then btn_spin: bet=3, credit=97, spinning=1 on the following cycle.
REQ-035 Spin with SPIN_DIV=4 and 8 frame_ticks: all reels advance by exactly 2; a 4-step wrap goes 3->0.
REQ-036 Force all reels to symbol 3 (stops timed), bet=3: win=1, win_amount=48, credit rises by 48 one cycle after EVAL.
REQ-037 No btn_stop for 3*AUTO_STOP frames: three auto-stops occur, EVAL is reached, and spinning falls to 0.
REQ-038 Credit=1 with bet=2, press btn_spin: no state change; credit=998 plus a payout of 48 saturates to 999.
REQ-039 Stop coincident with the SPIN_DIV tick: the stopped reel holds its value while the others step; rst asserted in SPIN2 returns all outputs to their reset values.

Source files
------------

// File: rtl/slot_game_ctrl.sv
// rtl/slot_game_ctrl.sv - slot machine controller: bet/spin handling, three-reel stop sequence, payout
// All outputs come straight from registers; reels advance on a frame_tick divider while spinning.
module slot_game_ctrl #(
  parameter int SPIN_DIV    = 4,
  parameter int AUTO_STOP   = 120,
  parameter int CREDIT_INIT = 100,
  parameter int CREDIT_MAX  = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_spin,
  input  logic       btn_bet,
  input  logic       btn_stop,
  output logic [1:0] reel0,
  output logic [1:0] reel1,
  output logic [1:0] reel2,
  output logic [9:0] credit,
  output logic [1:0] bet,
  output logic       spinning,
  output logic       win,
  output logic [9:0] win_amount
);
  localparam int DIV_W  = $clog2(SPIN_DIV + 1);
  localparam int AUTO_W = $clog2(AUTO_STOP + 1);

  typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, EVAL} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [AUTO_W-1:0] auto_q, auto_d;
  logic [1:0]        reel0_q, reel1_q, reel2_q, bet_q;
  logic [9:0]        credit_q, win_amount_q;
  logic              spinning_q, win_q;

  logic              in_spin, step, auto_hit, stop;
  logic              step0, step1, step2, can_spin;
  logic [9:0]        mult, payout, credit_sat;
  logic [10:0]       sum;

  always_comb begin
    in_spin  = (state_q == SPIN3) || (state_q == SPIN2) || (state_q == SPIN1);
    div_d    = div_q;
    auto_d   = auto_q;
    step     = 1'b0;
    auto_hit = 1'b0;
    if (in_spin && frame_tick) begin
      if (div_q == DIV_W'(SPIN_DIV - 1)) begin
        div_d = '0;
        step  = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (auto_q == AUTO_W'(AUTO_STOP - 1)) auto_hit = 1'b1;
      else                                  auto_d   = auto_q + AUTO_W'(1);
    end
    // a button stop and an auto-stop in the same cycle collapse into one stop
    stop = in_spin && (btn_stop || auto_hit);
    if (stop) auto_d = '0;

    // the reel being frozen by this stop must not take the coincident step
    step0 = step && (state_q == SPIN3) && !stop;
    step1 = step && ((state_q == SPIN3) || ((state_q == SPIN2) && !stop));
    step2 = step && in_spin && !((state_q == SPIN1) && stop);

    case (reel0_q)
      2'd0:    mult = 10'd2;
      2'd1:    mult = 10'd4;
      2'd2:    mult = 10'd8;
      default: mult = 10'd16;
    endcase
    if ((reel0_q == reel1_q) && (reel1_q == reel2_q))   payout = mult * {8'd0, bet_q};
    else if ((reel0_q == reel1_q) || (reel1_q == reel2_q)) payout = {8'd0, bet_q};
    else                                                payout = 10'd0;

    sum        = {1'b0, credit_q} + {1'b0, payout};
    credit_sat = (sum > 11'(CREDIT_MAX)) ? 10'(CREDIT_MAX) : sum[9:0];
    can_spin   = credit_q >= {8'd0, bet_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      auto_q       <= '0;
      reel0_q      <= 2'd0;
      reel1_q      <= 2'd0;
      reel2_q      <= 2'd0;
      credit_q     <= 10'(CREDIT_INIT);
      bet_q        <= 2'd1;
      spinning_q   <= 1'b0;
      win_q        <= 1'b0;
      win_amount_q <= 10'd0;
    end else begin
      div_q  <= div_d;
      auto_q <= auto_d;
      if (step0) reel0_q <= reel0_q + 2'd1;
      if (step1) reel1_q <= reel1_q + 2'd1;
      if (step2) reel2_q <= reel2_q + 2'd1;
      case (state_q)
        IDLE: begin
          if (btn_spin && can_spin) begin
            credit_q     <= credit_q - {8'd0, bet_q};
            win_q        <= 1'b0;
            win_amount_q <= 10'd0;
            div_q        <= '0;
            auto_q       <= '0;
            spinning_q   <= 1'b1;
            state_q      <= SPIN3;
          end else if (btn_bet) begin
            bet_q <= (bet_q == 2'd3) ? 2'd1 : bet_q + 2'd1;
          end
        end
        SPIN3: if (stop) state_q <= SPIN2;
        SPIN2: if (stop) state_q <= SPIN1;
        SPIN1: begin
          if (stop) begin
            state_q    <= EVAL;
            spinning_q <= 1'b0;
          end
        end
        EVAL: begin
          credit_q     <= credit_sat;
          win_q        <= (payout != 10'd0);
          win_amount_q <= payout;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reel0      = reel0_q;
  assign reel1      = reel1_q;
  assign reel2      = reel2_q;
  assign credit     = credit_q;
  assign bet        = bet_q;
  assign spinning   = spinning_q;
  assign win        = win_q;
  assign win_amount = win_amount_q;
endmodule
